// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter feeding a signed divide-by-2^n unit (arithmetic right shift).
// Optional build macro SHIFT_ROUND_EN rounds negative results toward zero instead of toward minus infinity.
module shift_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic [2:0] req0_shift,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic [2:0] req1_shift,
    output logic       req1_ready,
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic       res_id,
    input  logic       res_ready,
    output logic       busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_op_data;
    logic [2:0] r_op_shift;
    logic       r_op_id;
    logic       r_last_grant;
    logic [7:0] r_res_data;
    logic       r_res_id;
    logic       r_res_valid;
    logic       r_busy;

    logic       w_grant_id;
    logic       w_accept;
    logic [7:0] w_shifted;
    logic [7:0] w_result;

    // Round-robin choice: on a tie the requester not granted last wins.
    always_comb begin
        w_grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant_id = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant_id = 1'b1;
        end else begin
            w_grant_id = 1'b0;
        end
    end

    assign req0_ready = !rst && (r_state == IDLE) && req0_valid && !w_grant_id;
    assign req1_ready = !rst && (r_state == IDLE) && req1_valid &&  w_grant_id;
    assign w_accept   = req0_ready | req1_ready;

    assign w_shifted = $signed(r_op_data) >>> r_op_shift;

`ifdef SHIFT_ROUND_EN
    logic [7:0] w_lost_mask;
    assign w_lost_mask = ~(8'hFF << r_op_shift);
    // A negative value that lost nonzero bits was floored; bump it back toward zero.
    assign w_result = (r_op_data[7] && (|(r_op_data & w_lost_mask))) ? (w_shifted + 8'd1) : w_shifted;
`else
    assign w_result = w_shifted;
`endif

    // Control FSM with operand capture and registered result/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_op_data    <= 8'h00;
            r_op_shift   <= 3'd0;
            r_op_id      <= 1'b0;
            r_last_grant <= 1'b1;
            r_res_data   <= 8'h00;
            r_res_id     <= 1'b0;
            r_res_valid  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op_data    <= w_grant_id ? req1_data  : req0_data;
                        r_op_shift   <= w_grant_id ? req1_shift : req0_shift;
                        r_op_id      <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_busy       <= 1'b1;
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    r_res_data  <= w_result;
                    r_res_id    <= r_op_id;
                    r_res_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;
    assign busy      = r_busy;
endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: stimulus queues expected results, a negedge monitor checks them.
module tb_shift_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;
    logic [2:0] req0_shift, req1_shift;
    logic       req0_ready, req1_ready;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_id;
    logic       res_ready;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [8:0] exp_q[$];
    int acc_q[$];
    logic prev_rv = 1'b0;

    shift_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_shift(req0_shift), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_shift(req1_shift), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_ready(res_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: ready exclusivity, result latency and scoreboard comparison.
    always @(negedge clk) begin
        if (rst) begin
            acc_q.delete();
            prev_rv = 1'b0;
            chk("rst_ready_low", {31'd0, req0_ready | req1_ready}, 32'd0);
        end else begin
            chk("one_hot_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready))
                acc_q.push_back(cyc);
            if (res_valid && !prev_rv) begin
                if (acc_q.size() == 0) begin
                    chk("unexpected_res_valid", 32'd1, 32'd0);
                end else begin
                    int a;
                    a = acc_q.pop_front();
                    chk("latency", cyc - a, 32'd2);
                end
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", {23'd0, res_id, res_data}, 32'h1ff);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    chk("result_id_data", {23'd0, res_id, res_data}, {23'd0, e});
                end
            end
            prev_rv = res_valid;
        end
    end

    task automatic issue(input logic id, input logic [7:0] d, input logic [2:0] s,
                         input logic [7:0] exp_d, input bit expect_res);
        bit acc;
        acc = 1'b0;
        if (expect_res) exp_q.push_back({id, exp_d});
        if (id) begin
            req1_valid = 1'b1; req1_data = d; req1_shift = s;
        end else begin
            req0_valid = 1'b1; req0_data = d; req0_shift = s;
        end
        for (int i = 0; i < 30 && !acc; i++) begin
            @(negedge clk);
            acc = id ? req1_ready : req0_ready;
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = !busy && (exp_q.size() == 0);
        end
        if (!ok) chk("drain_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        res_ready = 1'b1;
        req0_valid = 1'b1; req0_data = 8'h11; req0_shift = 3'd1;
        req1_valid = 1'b1; req1_data = 8'h22; req1_shift = 3'd1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_data", {24'd0, res_data}, 32'd0);
        chk("rst_res_id", {31'd0, res_id}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic divides, both rounding modes of the bench model.
        issue(1'b0, 8'h64, 3'd2, 8'h19, 1'b1);
`ifdef SHIFT_ROUND_EN
        issue(1'b1, 8'hF9, 3'd1, 8'hFD, 1'b1);
        issue(1'b0, 8'h9C, 3'd3, 8'hF4, 1'b1);
`else
        issue(1'b1, 8'hF9, 3'd1, 8'hFC, 1'b1);
        issue(1'b0, 8'h9C, 3'd3, 8'hF3, 1'b1);
`endif
        issue(1'b1, 8'h80, 3'd7, 8'hFF, 1'b1);
        issue(1'b0, 8'h7F, 3'd7, 8'h00, 1'b1);
        issue(1'b1, 8'h80, 3'd0, 8'h80, 1'b1);
        issue(1'b0, 8'hF8, 3'd2, 8'hFE, 1'b1);
        wait_idle();

        // Both requesters held valid: alternating grants starting with requester 0.
        pulse_reset();
        req0_data = 8'h10; req0_shift = 3'd1;
        req1_data = 8'h40; req1_shift = 3'd1;
        exp_q.push_back({1'b0, 8'h08});
        exp_q.push_back({1'b1, 8'h20});
        exp_q.push_back({1'b0, 8'h08});
        exp_q.push_back({1'b1, 8'h20});
        req0_valid = 1'b1; req1_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                chk("grant_order", {31'd0, req1_ready}, n % 2);
                n++;
            end
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("grant_count", n, 32'd4);
        wait_idle();

        // Back-pressure in DONE with in-flight input changes.
        res_ready = 1'b0;
        issue(1'b0, 8'h33, 3'd1, 8'h19, 1'b1);
        req0_data = 8'hAA; req0_shift = 3'd5;
        req1_valid = 1'b1; req1_data = 8'h55;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_res_valid", {31'd0, res_valid}, 32'd1);
            chk("hold_res_data", {24'd0, res_data}, 32'h19);
            chk("hold_res_id", {31'd0, res_id}, 32'd0);
            chk("hold_ready_low", {31'd0, req0_ready | req1_ready}, 32'd0);
            chk("hold_busy", {31'd0, busy}, 32'd1);
            @(posedge clk); #1;
        end
        req1_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("release_busy", {31'd0, busy}, 32'd0);
        chk("release_res_valid", {31'd0, res_valid}, 32'd0);
        @(posedge clk); #1;

        // Reset during EXEC aborts the operation entirely.
        issue(1'b1, 8'h50, 3'd2, 8'h14, 1'b0);
        pulse_reset();
        @(negedge clk);
        chk("abort_res_valid", {31'd0, res_valid}, 32'd0);
        chk("abort_res_data", {24'd0, res_data}, 32'd0);
        chk("abort_res_id", {31'd0, res_id}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 6; i++) @(posedge clk);
        #1;
        issue(1'b1, 8'hC0, 3'd3, 8'hF8, 1'b1);
        wait_idle();

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
